// File: rtl/ndata_stream_arbiter_pkg.sv
// Shared stream definitions: arbiter state encoding and the modulo-N round-robin step.
package stream_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    localparam int PKT_CNT_W = 32;

    // Explicit compare so non-power-of-two input counts wrap correctly
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ndata_stream_arbiter_if.sv
// ndata stream bundle: NUM_ELEMENTS lanes of data_t with per-lane keep, packet last and valid/ready.
interface ndata_i #(
    parameter type data_t       = logic [31:0],
    parameter int  NUM_ELEMENTS = 8
);
    localparam int DATA_W = NUM_ELEMENTS * $bits(data_t);

    logic [DATA_W-1:0]       data;
    logic [NUM_ELEMENTS-1:0] keep;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport m (output data, keep, last, valid, input ready);
    modport s (input data, keep, last, valid, output ready);

endinterface

// File: rtl/ndata_stream_arbiter_pick.sv
// Combinational rotating priority search: first set valid bit starting at 'start', wrapping mod NUM_INPUTS.
module rr_priority_pick
    import stream_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic [NUM_INPUTS-1:0] valid,
    input  logic [IDX_W-1:0]      start,
    output logic                  found,
    output logic [IDX_W-1:0]      idx
);

    int unsigned cand;

    // Walk from farthest to nearest so the nearest valid candidate wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            cand = 32'(start) + 32'(k);
            if (cand >= 32'(NUM_INPUTS)) begin
                cand = cand - 32'(NUM_INPUTS);
            end
            if (valid[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ndata_stream_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_INPUTS ndata streams onto one output lane.
// Optional per-input completed-packet counters are enabled with `define ARB_PKT_COUNT_EN.
module ndata_stream_arbiter
    import stream_pkg::*;
#(
    parameter type data_t       = logic [31:0],
    parameter int  NUM_ELEMENTS = 8,
    parameter int  NUM_INPUTS   = 4,
    localparam int IDX_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    ndata_i.s                inp [NUM_INPUTS],
    ndata_i.m                out,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy
`ifdef ARB_PKT_COUNT_EN
    ,
    output logic [NUM_INPUTS*PKT_CNT_W-1:0] pkt_count
`endif
);

    localparam int DATA_W = NUM_ELEMENTS * $bits(data_t);

    logic [DATA_W-1:0]       in_data  [NUM_INPUTS];
    logic [NUM_ELEMENTS-1:0] in_keep  [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]   in_last;
    logic [NUM_INPUTS-1:0]   in_valid;
    logic [NUM_INPUTS-1:0]   in_ready;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] g;
    logic             g_valid;
    logic             g_last;
    logic             out_valid;
    logic             hs;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
        assign in_data[i]   = inp[i].data;
        assign in_keep[i]   = inp[i].keep;
        assign in_last[i]   = inp[i].last;
        assign in_valid[i]  = inp[i].valid;
        assign inp[i].ready = in_ready[i];
    end

    rr_priority_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .valid (in_valid),
        .start (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Outputs are gated while reset is held so an abandoned packet cannot leak a handshake
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        g          = pick_idx;
        g_valid    = pick_found;
        if (state_q == ARB_LOCKED) begin
            g       = lock_idx_q;
            g_valid = in_valid[lock_idx_q];
        end
        g_last    = in_last[g];
        out_valid = g_valid & ~rst;
        hs        = out_valid & out.ready;

        case (state_q)
            ARB_IDLE: begin
                if (hs) begin
                    if (g_last) begin
                        rr_ptr_d = IDX_W'(rr_next(32'(g), NUM_INPUTS));
                    end else begin
                        state_d    = ARB_LOCKED;
                        lock_idx_d = g;
                    end
                end
            end
            ARB_LOCKED: begin
                if (hs && g_last) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = IDX_W'(rr_next(32'(lock_idx_q), NUM_INPUTS));
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_ready[i] = (g == IDX_W'(i)) & out.ready & ~rst;
        end
    end

    assign out.data  = in_data[g];
    assign out.keep  = in_keep[g];
    assign out.last  = g_last;
    assign out.valid = out_valid;
    assign grant_idx = g;
    assign busy      = (state_q == ARB_LOCKED);

`ifdef ARB_PKT_COUNT_EN
    logic [PKT_CNT_W-1:0] cnt_q [NUM_INPUTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (hs && g_last) begin
            cnt_q[g] <= cnt_q[g] + PKT_CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_cnt
        assign pkt_count[i*PKT_CNT_W +: PKT_CNT_W] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_ndata_stream_arbiter.sv
// Self-checking bench for ndata_stream_arbiter: per-input producer queues, ordered expected-output model.
module tb_ndata_stream_arbiter;

    localparam int N  = 4;
    localparam int NE = 8;
    localparam int DW = NE * 32;
    localparam int CW = DW + 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NE-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [1:0] src;
        beat_t      beat;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant_idx;
    logic       busy;
`ifdef ARB_PKT_COUNT_EN
    logic [N*32-1:0] pkt_count;
`endif

    ndata_i #(.data_t(logic [31:0]), .NUM_ELEMENTS(NE)) in_bus [N] ();
    ndata_i #(.data_t(logic [31:0]), .NUM_ELEMENTS(NE)) out_bus ();

    logic [N-1:0] drv_valid;
    logic [N-1:0] mon_ready;
    beat_t        drv_beat [N];
    logic         out_ready;

    for (genvar i = 0; i < N; i++) begin : g_drv
        assign in_bus[i].valid = drv_valid[i];
        assign in_bus[i].data  = drv_beat[i].data;
        assign in_bus[i].keep  = drv_beat[i].keep;
        assign in_bus[i].last  = drv_beat[i].last;
        assign mon_ready[i]    = in_bus[i].ready;
    end
    assign out_bus.ready = out_ready;

    ndata_stream_arbiter #(
        .data_t       (logic [31:0]),
        .NUM_ELEMENTS (NE),
        .NUM_INPUTS   (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (in_bus),
        .out       (out_bus),
        .grant_idx (grant_idx),
`ifdef ARB_PKT_COUNT_EN
        .pkt_count (pkt_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    beat_t        q [N][$];
    rec_t         out_log[$];
    rec_t         exp_log[$];
    int           out_cyc[$];
    int           hold [N];
    int           hs_total [N];
    int           cyc;
    int           checks;
    int           fails;
    logic [7:0]   salt;
    logic         rand_ready;
    logic         snap_ovalid;
    logic         snap_busy;
    logic [1:0]   snap_grant;
    logic [N-1:0] snap_ready;

    task automatic check_output(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload is derived purely from (source, packet, beat) so the model can recompute it independently
    function automatic beat_t mk_beat(input int src, input int pkt, input int b, input int nb);
        beat_t      r;
        logic [31:0] w;
        w      = {8'(src), 8'(pkt), 8'(b), salt};
        r.data = {NE{w}};
        r.keep = 8'(src * 37 + pkt * 11 + b * 5) ^ salt;
        r.last = (b == nb - 1);
        return r;
    endfunction

    task automatic load_pkt(input int src, input int pkt, input int nb);
        for (int b = 0; b < nb; b++) q[src].push_back(mk_beat(src, pkt, b, nb));
    endtask

    task automatic add_exp(input int src, input int pkt, input int nb);
        rec_t r;
        for (int b = 0; b < nb; b++) begin
            r.src  = 2'(src);
            r.beat = mk_beat(src, pkt, b, nb);
            exp_log.push_back(r);
        end
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic apply_stimulus();
        for (int i = 0; i < N; i++) begin
            drv_valid[i] = (q[i].size() > 0) && (hold[i] == 0);
            drv_beat[i]  = (q[i].size() > 0) ? q[i][0] : '0;
        end
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Observe at the falling edge, commit producer pops after the rising edge
    task automatic step();
        logic [N-1:0] hs;
        rec_t         r;
        @(negedge clk);
        hs          = drv_valid & mon_ready;
        snap_ovalid = out_bus.valid;
        snap_busy   = busy;
        snap_grant  = grant_idx;
        snap_ready  = mon_ready;
        if (out_bus.valid && out_ready) begin
            r.src       = grant_idx;
            r.beat.data = out_bus.data;
            r.beat.keep = out_bus.keep;
            r.beat.last = out_bus.last;
            out_log.push_back(r);
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                void'(q[i].pop_front());
                hs_total[i]++;
            end
            if (hold[i] > 0) hold[i]--;
        end
        apply_stimulus();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while ((out_log.size() < n || !queues_empty()) && c < budget) begin
            step();
            c++;
        end
        check_output({tag, "_beats"}, CW'(out_log.size()), CW'(n));
    endtask

    task automatic compare_log(input string tag);
        for (int k = 0; k < exp_log.size(); k++) begin
            if (k < out_log.size()) begin
                check_output($sformatf("%s_src%0d", tag, k), CW'(out_log[k].src), CW'(exp_log[k].src));
                check_output($sformatf("%s_beat%0d", tag, k), CW'(out_log[k].beat), CW'(exp_log[k].beat));
            end
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        rand_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            hold[i]     = 0;
            hs_total[i] = 0;
        end
        apply_stimulus();
        out_log.delete();
        exp_log.delete();
        out_cyc.delete();
        salt = 8'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_busy", CW'(busy), CW'(0));
        check_output("rst_out_valid", CW'(out_bus.valid), CW'(0));
        check_output("rst_grant", CW'(grant_idx), CW'(0));
        check_output("rst_ready", CW'(mon_ready), CW'(0));
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int span;
        int n1;
        int n3;
        int tot;
        checks     = 0;
        fails      = 0;
        cyc        = 0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drv_valid  = '0;
        for (int i = 0; i < N; i++) drv_beat[i] = '0;

        // 1: one 3-beat packet per input, back-to-back in index order
        do_reset();
        for (int s = 0; s < N; s++) begin
            load_pkt(s, 0, 3);
            add_exp(s, 0, 3);
        end
        apply_stimulus();
        run_until(12, 200, "t1");
        compare_log("t1");
        span = (out_cyc.size() >= 12) ? out_cyc[11] - out_cyc[0] : -1;
        check_output("t1_no_gaps", CW'(span), CW'(11));

        // 2: granted producer stalls mid-packet; competitor must stay blocked
        do_reset();
        load_pkt(0, 1, 4);
        load_pkt(1, 1, 2);
        add_exp(0, 1, 4);
        add_exp(1, 1, 2);
        apply_stimulus();
        for (int c = 0; c < 50 && hs_total[0] < 2; c++) step();
        hold[0] = 3;
        apply_stimulus();
        for (int c = 0; c < 3; c++) begin
            step();
            check_output($sformatf("t2_hold_valid%0d", c), CW'(snap_ovalid), CW'(0));
            check_output($sformatf("t2_hold_busy%0d", c), CW'(snap_busy), CW'(1));
            check_output($sformatf("t2_hold_grant%0d", c), CW'(snap_grant), CW'(0));
            check_output($sformatf("t2_hold_rdy1_%0d", c), CW'(snap_ready[1]), CW'(0));
        end
        run_until(6, 200, "t2");
        compare_log("t2");

        // 3: continuous single-beat packets from all inputs with random backpressure
        do_reset();
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            load_pkt(k % N, k / N, 1);
            add_exp(k % N, k / N, 1);
        end
        apply_stimulus();
        run_until(40, 2000, "t3");
        compare_log("t3");
        rand_ready = 1'b0;

        // 4: pointer parked at 3 by a lone in2 packet, then in3 and in0 compete
        do_reset();
        load_pkt(2, 0, 1);
        add_exp(2, 0, 1);
        apply_stimulus();
        run_until(1, 100, "t4a");
        load_pkt(3, 0, 1);
        load_pkt(0, 0, 1);
        add_exp(3, 0, 1);
        add_exp(0, 0, 1);
        apply_stimulus();
        run_until(3, 100, "t4b");
        compare_log("t4");

        // 5: reset in the middle of a 5-beat in0 packet (pointer was 3 beforehand)
        out_log.delete();
        exp_log.delete();
        load_pkt(2, 1, 1);
        apply_stimulus();
        run_until(1, 100, "t5a");
        n1 = hs_total[0];
        load_pkt(0, 2, 5);
        apply_stimulus();
        for (int c = 0; c < 50 && hs_total[0] < n1 + 2; c++) step();
        rst = 1'b1;
        step();
        check_output("t5_rst_busy", CW'(snap_busy), CW'(0));
        check_output("t5_rst_valid", CW'(snap_ovalid), CW'(0));
        check_output("t5_rst_ready", CW'(snap_ready), CW'(0));
        q[0].delete();
        out_log.delete();
        rst = 1'b0;
        load_pkt(2, 3, 2);
        load_pkt(3, 3, 1);
        add_exp(2, 3, 2);
        add_exp(3, 3, 1);
        apply_stimulus();
        run_until(3, 100, "t5b");
        compare_log("t5");

`ifdef ARB_PKT_COUNT_EN
        // 6: completed-packet counters
        do_reset();
        rand_ready = 1'b1;
        tot = 0;
        n1  = 7;
        n3  = 2;
        for (int p = 0; p < n1; p++) begin
            int nb;
            nb = $urandom_range(1, 3);
            load_pkt(1, p, nb);
            tot += nb;
        end
        for (int p = 0; p < n3; p++) begin
            int nb;
            nb = $urandom_range(1, 3);
            load_pkt(3, p, nb);
            tot += nb;
        end
        apply_stimulus();
        run_until(tot, 1000, "t6");
        check_output("t6_cnt0", CW'(pkt_count[0 +: 32]), CW'(0));
        check_output("t6_cnt1", CW'(pkt_count[32 +: 32]), CW'(n1));
        check_output("t6_cnt2", CW'(pkt_count[64 +: 32]), CW'(0));
        check_output("t6_cnt3", CW'(pkt_count[96 +: 32]), CW'(n3));
        rand_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
